io_ctrl: RTL and testbench

//  Peripheral block downstream of the memory/IO address decoder. Consumes io_addr/io_wdata/io_we,

---
 rtl/io_ctrl_pkg.sv | 22 ++
 rtl/io_ctrl_if.sv | 9 +
 rtl/io_ctrl_uart_tx_fifo.sv | 73 +++++++
 rtl/io_ctrl.sv | 78 +++++++
 tb/tb_io_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: peripheral address map, UART state encoding and status layout
package io_ctrl_pkg;
  localparam logic [31:0] PERIPHERAL_ADDR_LOW = 32'h1000_0000;
  localparam logic [31:0] IO_OFF_LED = 32'h00;
  localparam logic [31:0] IO_OFF_SW = 32'h04;
  localparam logic [31:0] IO_OFF_TCNT = 32'h08;
  localparam logic [31:0] IO_OFF_TCMP = 32'h0C;
  localparam logic [31:0] IO_OFF_TCTRL = 32'h10;
  localparam logic [31:0] IO_OFF_UTX = 32'h14;
  localparam logic [31:0] IO_OFF_USTAT = 32'h18;
  localparam logic [31:0] IO_OFF_END = 32'h1C;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;
  typedef struct packed {
    logic ovf;
    logic busy;
    logic empty;
    logic full;
  } ustat_t;
endpackage

// File: rtl/io_ctrl_if.sv
// io_ctrl_if: decoded CPU bus into the peripheral block
interface io_ctrl_if;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic io_we;
  modport master (output io_addr, io_wdata, io_we, input io_rdata);
  modport slave (input io_addr, io_wdata, io_we, output io_rdata);
endinterface

// File: rtl/io_ctrl_uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serialiser with registered line output
module uart_tx_fifo
  import io_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0] st_q, st_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d, ovf_q, ovf_d, pop, do_push, adv;
  always_comb begin
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    empty = cnt_q == '0;
    busy = st_q != ST_IDLE;
    pop = !busy && !empty;
    do_push = push && (!full || pop);
    adv = busy && baud_q == BW'(BAUD_DIV - 1);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
    ovf_d = (push && !do_push) || (ovf_q && !ovf_clr);
    st_d = pop ? ST_START : adv && !(st_q == ST_DATA && bit_q != 3'd7) ? st_q + 2'd1 : st_q;
    baud_d = pop || adv ? '0 : busy ? baud_q + BW'(1) : baud_q;
    bit_d = st_q == ST_DATA ? bit_q + 3'(adv) : 3'd0;
    sh_d = pop ? mem_q[rd_q] : adv && st_q == ST_DATA ? sh_q >> 1 : sh_q;
    tx_d = st_d == ST_START ? 1'b0 : st_d == ST_DATA ? sh_d[0] : 1'b1;
    ovf = ovf_q;
    tx = tx_q;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      st_q <= ST_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: LED/switch/timer/UART peripheral registers behind the IO decoder
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int SW_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV = 868
) (
  input  logic             clk,
  input  logic             rst,
  io_ctrl_if.slave         bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             uart_tx
);
  logic [31:0] off, word, tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw1_q, sw2_q;
  logic en_q, en_d, match_q, match_d, in_rng, tmatch;
  logic hit_led, hit_sw, hit_tcnt, hit_tcmp, hit_tctrl, hit_utx, hit_ustat;
  logic full, empty, busy, ovf;
  ustat_t stat;
  always_comb begin
    off = bus.io_addr - PERIPHERAL_ADDR_LOW;
    word = off & ~32'h3;
    in_rng = off < IO_OFF_END;
    hit_led = in_rng && word == IO_OFF_LED;
    hit_sw = in_rng && word == IO_OFF_SW;
    hit_tcnt = in_rng && word == IO_OFF_TCNT;
    hit_tcmp = in_rng && word == IO_OFF_TCMP;
    hit_tctrl = in_rng && word == IO_OFF_TCTRL;
    hit_utx = in_rng && word == IO_OFF_UTX;
    hit_ustat = in_rng && word == IO_OFF_USTAT;
    tmatch = en_q && tcnt_q == tcmp_q;
    led_d = bus.io_we && hit_led ? bus.io_wdata[LED_W-1:0] : led_q;
    tcmp_d = bus.io_we && hit_tcmp ? bus.io_wdata : tcmp_q;
    tcnt_d = bus.io_we && hit_tcnt ? bus.io_wdata : tmatch ? 32'd0 : tcnt_q + 32'(en_q);
    en_d = bus.io_we && hit_tctrl ? bus.io_wdata[0] : en_q;
    match_d = tmatch || (match_q && !(bus.io_we && hit_tctrl && bus.io_wdata[1]));
    stat = '{ovf: ovf, busy: busy, empty: empty, full: full};
    bus.io_rdata = hit_led ? 32'(led_q) : hit_sw ? 32'(sw2_q) : hit_tcnt ? tcnt_q :
                   hit_tcmp ? tcmp_q : hit_tctrl ? {30'd0, match_q, en_q} :
                   hit_ustat ? 32'(stat) : 32'd0;
    led = led_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      tcnt_q <= '0;
      tcmp_q <= 32'hFFFF_FFFF;
      en_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      led_q <= led_d;
      sw1_q <= sw;
      sw2_q <= sw1_q;
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      en_q <= en_d;
      match_q <= match_d;
    end
  end
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk),
    .rst(rst),
    .push(bus.io_we && hit_utx),
    .din(bus.io_wdata[7:0]),
    .ovf_clr(bus.io_we && hit_ustat),
    .full(full),
    .empty(empty),
    .busy(busy),
    .ovf(ovf),
    .tx(uart_tx)
  );
endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed and randomized register/UART checks against a bit-level line model
module tb_io_ctrl;
  import io_ctrl_pkg::*;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic [15:0] sw = '0;
  logic [15:0] led;
  int vectors = 0;
  int miscompares = 0;
  int frame_err = 0;
  logic mon_en = 1'b0;
  logic [7:0] mon_b;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  io_ctrl_if bus();
  io_ctrl #(.LED_W(16), .SW_W(16), .FIFO_DEPTH(4), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw(sw), .led(led), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [31:0] o, output logic [31:0] d);
    bus.io_addr = PERIPHERAL_ADDR_LOW + o;
    #1 d = bus.io_rdata;
    bus.io_addr = '0;
  endtask
  task automatic chkr(input string tag, input logic [31:0] o, input logic [31:0] exp);
    logic [31:0] d;
    rd(o, d);
    chk(tag, d, exp);
  endtask
  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    bus.io_addr = PERIPHERAL_ADDR_LOW + o;
    bus.io_wdata = d;
    bus.io_we = 1'b1;
    tick();
    bus.io_we = 1'b0;
    bus.io_addr = '0;
    bus.io_wdata = '0;
  endtask
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int i;
    i = k / BD;
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction
  task automatic wait_rx(input int n, input string tag);
    int c;
    c = 0;
    while (rx.size() < n && c < 400) begin tick(); c++; end
    chk(tag, rx.size(), n);
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (mon_en && !rst && uart_tx === 1'b0) begin
      tick(BD / 2);
      for (int i = 0; i < 8; i++) begin
        tick(BD);
        mon_b[i] = uart_tx;
      end
      tick(BD);
      if (uart_tx !== 1'b1) frame_err++;
      rx.push_back(mon_b);
      tick(1);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v, o;
    int n, acc, lows;
    bus.io_addr = '0;
    bus.io_wdata = '0;
    bus.io_we = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chkr("rst_ustat", IO_OFF_USTAT, 32'h2);
    chkr("rst_tcmp", IO_OFF_TCMP, 32'hFFFF_FFFF);
    chkr("rst_utx_rd", IO_OFF_UTX, 32'h0);
    chkr("rst_tcnt", IO_OFF_TCNT, 32'h0);
    chkr("rst_tctrl", IO_OFF_TCTRL, 32'h0);
    mon_en = 1'b1;
    wr(IO_OFF_LED, 32'hDEAD_BEEF);
    chk("led_pin", 32'(led), 32'hBEEF);
    chkr("led_rd", IO_OFF_LED, 32'h0000_BEEF);
    sw = 16'h1234;
    tick();
    chkr("sw_lag1", IO_OFF_SW, 32'h0);
    tick();
    chkr("sw_lag2", IO_OFF_SW, 32'h1234);
    wr(IO_OFF_TCMP, 32'd5);
    wr(IO_OFF_TCTRL, 32'h1);
    for (int i = 0; i <= 5; i++) begin
      chkr("tcnt_run", IO_OFF_TCNT, i);
      chkr("tctrl_run", IO_OFF_TCTRL, 32'h1);
      tick();
    end
    chkr("tcnt_wrap", IO_OFF_TCNT, 32'h0);
    chkr("match_set", IO_OFF_TCTRL, 32'h3);
    wr(IO_OFF_TCTRL, 32'h3);
    chkr("match_w1c", IO_OFF_TCTRL, 32'h1);
    wr(IO_OFF_TCMP, 32'd12);
    wr(IO_OFF_TCNT, 32'd10);
    chkr("tcnt_wr_beats_inc", IO_OFF_TCNT, 32'd10);
    chkr("match_clear_pre", IO_OFF_TCTRL, 32'h1);
    tick(2);
    wr(IO_OFF_TCTRL, 32'h3);
    chkr("match_set_beats_w1c", IO_OFF_TCTRL, 32'h3);
    chkr("tcnt_wrap2", IO_OFF_TCNT, 32'h0);
    wr(IO_OFF_TCTRL, 32'h2);
    chkr("timer_off", IO_OFF_TCTRL, 32'h0);
    rx.delete();
    wr(IO_OFF_UTX, 32'h0000_01A5);
    for (int k = 0; k < 10 * BD; k++) begin
      tick();
      chk("a5_line", 32'(uart_tx), 32'(exp_bit(8'hA5, k)));
      rd(IO_OFF_USTAT, v);
      chk("a5_busy", 32'(v[2]), 32'h1);
    end
    tick();
    chkr("a5_idle", IO_OFF_USTAT, 32'h2);
    chk("a5_mon", rx.size() == 1 ? 32'(rx[0]) : 32'hFFFF_FFFF, 32'hA5);
    rx.delete();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (exp_q[i]) wr(IO_OFF_UTX, 32'(exp_q[i]));
    wr(IO_OFF_UTX, 32'h66);
    chkr("ovf_full", IO_OFF_USTAT, 32'hD);
    wr(IO_OFF_USTAT, 32'h0);
    chkr("ovf_clr", IO_OFF_USTAT, 32'h5);
    wait_rx(5, "burst_count");
    foreach (exp_q[i]) chk("burst_byte", 32'(rx[i]), 32'(exp_q[i]));
    tick(3);
    chkr("burst_idle", IO_OFF_USTAT, 32'h2);
    for (int r = 0; r < 8; r++) begin
      v = $urandom;
      wr(IO_OFF_LED, v);
      chk("rnd_led_pin", 32'(led), 32'(v[15:0]));
      chkr("rnd_led_sub", IO_OFF_LED + 32'(r % 4), 32'(v[15:0]));
      o = IO_OFF_END + 32'($urandom_range(0, 40)) * 4;
      wr(o, $urandom);
      chkr("rnd_unmapped", o, 32'h0);
      chkr("rnd_led_keep", IO_OFF_LED, 32'(v[15:0]));
      sw = 16'($urandom);
      tick(2);
      chkr("rnd_sw", IO_OFF_SW, 32'(sw));
      v = $urandom;
      wr(IO_OFF_TCMP, v);
      chkr("rnd_tcmp", IO_OFF_TCMP, v);
      rx.delete();
      exp_q.delete();
      n = $urandom_range(1, 7);
      acc = n > 5 ? 5 : n;
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        if (i < acc) exp_q.push_back(v[7:0]);
        wr(IO_OFF_UTX, v);
      end
      rd(IO_OFF_USTAT, v);
      chk("rnd_ovf", 32'(v[3]), 32'(n > 5));
      wr(IO_OFF_USTAT, 32'h0);
      wait_rx(acc, "rnd_count");
      foreach (exp_q[i]) chk("rnd_byte", 32'(rx[i]), 32'(exp_q[i]));
      tick(3);
      chkr("rnd_idle", IO_OFF_USTAT, 32'h2);
    end
    chk("frame_err", frame_err, 0);
    mon_en = 1'b0;
    wr(IO_OFF_UTX, 32'h3C);
    wr(IO_OFF_UTX, 32'h5A);
    wr(IO_OFF_UTX, 32'h96);
    tick(16);
    rst = 1'b1;
    tick();
    chk("rst_mid_tx", 32'(uart_tx), 32'h1);
    rst = 1'b0;
    chkr("rst_mid_ustat", IO_OFF_USTAT, 32'h2);
    chk("rst_mid_led", 32'(led), 32'h0);
    lows = 0;
    repeat (60) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    chk("rst_mid_quiet", lows, 0);
    chkr("rst_mid_empty", IO_OFF_USTAT, 32'h2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
